// File: rtl/branch_resolver.sv
// Branch resolver: evaluates B/CBZ/CBNZ/B.cond against forwarded NZVC flags and pulses a redirect.
// Optional saturating statistics counters are built only when BR_STATS_EN is defined.
module branch_resolver #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [1:0]        br_type,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic [DATA_W-1:0] br_reg,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic              flag_c,
    input  logic              flag_v,
    input  logic              flag_wr_en,
    input  logic              flag_n_in,
    input  logic              flag_z_in,
    input  logic              flag_c_in,
    input  logic              flag_v_in,
    input  logic              flag_pending,
    input  logic              kill,
    output logic              resolve_valid,
    output logic              resolve_taken,
    output logic [ADDR_W-1:0] resolve_target,
    output logic [CNT_W-1:0]  stat_resolved,
    output logic [CNT_W-1:0]  stat_taken
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        RESOLVE    = 2'd2
    } state_e;

    localparam logic [1:0] TYPE_B    = 2'b00;
    localparam logic [1:0] TYPE_CBZ  = 2'b01;
    localparam logic [1:0] TYPE_CBNZ = 2'b10;
    localparam logic [1:0] TYPE_BCC  = 2'b11;

    function automatic logic cond_pass(input logic [3:0] cond, input logic n, input logic z,
                                       input logic c, input logic v);
        logic r;
        r = 1'b1;
        case (cond)
            4'h0: r = z;
            4'h1: r = !z;
            4'h2: r = c;
            4'h3: r = !c;
            4'h4: r = n;
            4'h5: r = !n;
            4'h6: r = v;
            4'h7: r = !v;
            4'h8: r = c && !z;
            4'h9: r = !c || z;
            4'hA: r = (n == v);
            4'hB: r = (n != v);
            4'hC: r = !z && (n == v);
            4'hD: r = z || (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [3:0]          cond_q, cond_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic                taken_q, taken_d;
    logic [ADDR_W-1:0]   res_target_q, res_target_d;

    logic                n_eff, z_eff, c_eff, v_eff;
    logic [ADDR_W-1:0]   acc_target;
    logic                enter_res;
    logic                taken_new;
    logic [ADDR_W-1:0]   target_new;

    // Same-cycle flag writes bypass the flag register
    assign n_eff      = flag_wr_en ? flag_n_in : flag_n;
    assign z_eff      = flag_wr_en ? flag_z_in : flag_z;
    assign c_eff      = flag_wr_en ? flag_c_in : flag_c;
    assign v_eff      = flag_wr_en ? flag_v_in : flag_v;
    assign acc_target = br_pc + (br_offset << 2);

    always_comb begin
        state_d      = state_q;
        cond_d       = cond_q;
        target_d     = target_q;
        taken_d      = taken_q;
        res_target_d = res_target_q;
        enter_res    = 1'b0;
        taken_new    = 1'b0;
        target_new   = target_q;

        case (state_q)
            IDLE: begin
                if (!kill && br_valid) begin
                    cond_d     = br_cond;
                    target_d   = acc_target;
                    target_new = acc_target;
                    case (br_type)
                        TYPE_B: begin
                            enter_res = 1'b1;
                            taken_new = 1'b1;
                        end
                        TYPE_CBZ: begin
                            enter_res = 1'b1;
                            taken_new = (br_reg == '0);
                        end
                        TYPE_CBNZ: begin
                            enter_res = 1'b1;
                            taken_new = (br_reg != '0);
                        end
                        TYPE_BCC: begin
                            if (flag_pending && !flag_wr_en) begin
                                state_d = WAIT_FLAGS;
                            end else begin
                                enter_res = 1'b1;
                                taken_new = cond_pass(br_cond, n_eff, z_eff, c_eff, v_eff);
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            WAIT_FLAGS: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (flag_wr_en) begin
                    enter_res = 1'b1;
                    taken_new = cond_pass(cond_q, flag_n_in, flag_z_in, flag_c_in, flag_v_in);
                end
            end
            RESOLVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Result registers only change on entry to RESOLVE so they hold between pulses
        if (enter_res) begin
            state_d      = RESOLVE;
            taken_d      = taken_new;
            res_target_d = target_new;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cond_q       <= 4'h0;
            target_q     <= '0;
            taken_q      <= 1'b0;
            res_target_q <= '0;
        end else begin
            state_q      <= state_d;
            cond_q       <= cond_d;
            target_q     <= target_d;
            taken_q      <= taken_d;
            res_target_q <= res_target_d;
        end
    end

    // A kill landing in the RESOLVE cycle suppresses the pulse
    assign resolve_valid  = (state_q == RESOLVE) && !kill;
    assign br_ready       = (state_q == IDLE);
    assign resolve_taken  = taken_q;
    assign resolve_target = res_target_q;

`ifdef BR_STATS_EN
    logic [CNT_W-1:0] res_cnt_q, tak_cnt_q;

    // Saturating counters; never wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_cnt_q <= '0;
            tak_cnt_q <= '0;
        end else if (resolve_valid) begin
            if (res_cnt_q != '1) res_cnt_q <= res_cnt_q + CNT_W'(1);
            if (resolve_taken && (tak_cnt_q != '1)) tak_cnt_q <= tak_cnt_q + CNT_W'(1);
        end
    end

    assign stat_resolved = res_cnt_q;
    assign stat_taken    = tak_cnt_q;
`else
    assign stat_resolved = '0;
    assign stat_taken    = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed branches, kill/reset squashes, full cond x NZCV sweep.
module tb_branch_resolver;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CMAX   = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              br_valid = 1'b0;
    logic              br_ready;
    logic [1:0]        br_type = 2'b00;
    logic [3:0]        br_cond = 4'h0;
    logic [ADDR_W-1:0] br_pc = '0;
    logic [ADDR_W-1:0] br_offset = '0;
    logic [DATA_W-1:0] br_reg = '0;
    logic flag_n = 1'b0, flag_z = 1'b0, flag_c = 1'b0, flag_v = 1'b0;
    logic flag_wr_en = 1'b0;
    logic flag_n_in = 1'b0, flag_z_in = 1'b0, flag_c_in = 1'b0, flag_v_in = 1'b0;
    logic flag_pending = 1'b0;
    logic kill = 1'b0;
    logic              resolve_valid;
    logic              resolve_taken;
    logic [ADDR_W-1:0] resolve_target;
    logic [CNT_W-1:0]  stat_resolved;
    logic [CNT_W-1:0]  stat_taken;

    branch_resolver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .br_valid(br_valid), .br_ready(br_ready), .br_type(br_type), .br_cond(br_cond),
        .br_pc(br_pc), .br_offset(br_offset), .br_reg(br_reg),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .flag_wr_en(flag_wr_en),
        .flag_n_in(flag_n_in), .flag_z_in(flag_z_in), .flag_c_in(flag_c_in), .flag_v_in(flag_v_in),
        .flag_pending(flag_pending), .kill(kill),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .stat_resolved(stat_resolved), .stat_taken(stat_taken)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          taken;
        logic [63:0] target;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int unsigned exp_res = 0;
    int unsigned exp_tak = 0;
    bit prev_v = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned sat_inc(input int unsigned x);
        return (x == CMAX) ? x : x + 1;
    endfunction

    // ARM encoding: even/odd condition pairs are complements, except 4'hF
    function automatic bit cond_model(input logic [3:0] c, input bit n, input bit z,
                                      input bit cf, input bit v);
        bit base;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[0] && c != 4'hF) base = ~base;
        return base;
    endfunction

    task automatic push_exp(input bit taken, input logic [63:0] target);
        exp_t e;
        e.taken  = taken;
        e.target = target;
        e.cyc    = cyc;
        sb.push_back(e);
        exp_res = sat_inc(exp_res);
        if (taken) exp_tak = sat_inc(exp_tak);
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge
    task automatic issue(input logic [1:0] t, input logic [3:0] c, input logic [63:0] pc,
                         input logic [63:0] off, input logic [63:0] rg,
                         input bit expect_pulse, input bit exp_taken, input logic [63:0] exp_tgt);
        int n;
        n = 0;
        while (!br_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!br_ready) chk("ready_timeout", 64'(br_ready), 64'd1);
        br_valid  = 1'b1;
        br_type   = t;
        br_cond   = c;
        br_pc     = pc;
        br_offset = off;
        br_reg    = rg;
        @(posedge clk); #1;
        br_valid = 1'b0;
        if (expect_pulse) push_exp(exp_taken, exp_tgt);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_stats(input string name);
`ifdef BR_STATS_EN
        chk({name, "_resolved"}, 64'(stat_resolved), 64'(exp_res));
        chk({name, "_taken"}, 64'(stat_taken), 64'(exp_tak));
`else
        chk({name, "_resolved"}, 64'(stat_resolved), 64'd0);
        chk({name, "_taken"}, 64'(stat_taken), 64'd0);
`endif
    endtask

    // Monitor: every pulse must match the head of the scoreboard, in the expected cycle
    always @(negedge clk) begin
        if (resolve_valid) begin
            checks++;
            if (prev_v) begin
                errors++;
                $display("FAIL pulse_width: resolve_valid high two cycles in a row (cycle %0d)", cyc);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: taken=%0b target=0x%0h (cycle %0d)",
                         resolve_taken, resolve_target, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (resolve_taken !== e.taken || resolve_target !== e.target || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL resolve: got taken=%0b target=0x%0h cycle=%0d expected taken=%0b target=0x%0h cycle=%0d",
                             resolve_taken, resolve_target, cyc, e.taken, e.target, e.cyc);
                end
            end
        end
        prev_v = resolve_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int drain;
        logic [63:0] pc;
        logic [63:0] off;
        bit bn, bz, bc, bv, exp_t_bit;

        // Reset values
        idle_cycles(3);
        chk("rst_ready", 64'(br_ready), 64'd1);
        chk("rst_valid", 64'(resolve_valid), 64'd0);
        chk("rst_taken", 64'(resolve_taken), 64'd0);
        chk("rst_target", resolve_target, 64'd0);
        chk_stats("rst_stats");
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles(1);

        // B backwards: 0x1000 + (-4 << 2) = 0xFF0
        issue(2'b00, 4'h0, 64'h1000, -64'sd4, 64'd0, 1'b1, 1'b1, 64'h0FF0);
        idle_cycles(1);

        // CBZ with zero, then CBNZ with zero
        issue(2'b01, 4'h0, 64'h2000, 64'd8, 64'd0, 1'b1, 1'b1, 64'h2020);
        chk("ready_in_resolve", 64'(br_ready), 64'd0);
        issue(2'b10, 4'h0, 64'h3000, 64'd1, 64'd0, 1'b1, 1'b0, 64'h3004);
        idle_cycles(1);
        chk("hold_taken", 64'(resolve_taken), 64'd0);
        chk("hold_target", resolve_target, 64'h3004);

        // GT with N=V, Z=0 then Z=1
        flag_n = 1'b1; flag_v = 1'b1; flag_c = 1'b0; flag_z = 1'b0;
        issue(2'b11, 4'hC, 64'h8000_0000_0000_0000, 64'h3FFF_FFFF_FFFF_FFFF, 64'd0,
              1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFC);
        flag_z = 1'b1;
        issue(2'b11, 4'hC, 64'h100, 64'd2, 64'd5, 1'b1, 1'b0, 64'h108);
        idle_cycles(2);
        chk_stats("stats_5_branches");

        // EQ waits on a pending flag write
        flag_z = 1'b0; flag_pending = 1'b1;
        issue(2'b11, 4'h0, 64'h4000, 64'd16, 64'd0, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("wait_ready_low", 64'(br_ready), 64'd0);
            chk("wait_no_pulse", 64'(resolve_valid), 64'd0);
            @(posedge clk); #1;
        end
        flag_wr_en = 1'b1; flag_z_in = 1'b1;
        flag_n_in = 1'b0; flag_c_in = 1'b0; flag_v_in = 1'b0;
        @(posedge clk); #1;
        push_exp(1'b1, 64'h4040);
        flag_wr_en = 1'b0; flag_pending = 1'b0; flag_z = 1'b1;
        idle_cycles(2);
        chk_stats("stats_after_wait");

        // Kill during WAIT_FLAGS; a later flag write must not revive it
        flag_pending = 1'b1;
        issue(2'b11, 4'h1, 64'h5000, 64'd4, 64'd0, 1'b0, 1'b0, 64'd0);
        @(posedge clk); #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_wait_ready", 64'(br_ready), 64'd1);
        flag_wr_en = 1'b1; flag_z_in = 1'b0;
        @(posedge clk); #1;
        flag_wr_en = 1'b0; flag_pending = 1'b0;
        idle_cycles(2);
        chk_stats("stats_after_kill_wait");

        // Kill in the RESOLVE cycle suppresses the pulse
        issue(2'b00, 4'h0, 64'h6000, 64'd1, 64'd0, 1'b0, 1'b0, 64'd0);
        kill = 1'b1;
        #1;
        chk("kill_resolve_no_pulse", 64'(resolve_valid), 64'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_resolve_ready", 64'(br_ready), 64'd1);

        // Kill in IDLE blocks a same-cycle request
        kill = 1'b1; br_valid = 1'b1; br_type = 2'b00;
        @(posedge clk); #1;
        kill = 1'b0; br_valid = 1'b0;
        chk("kill_idle_not_accepted", 64'(br_ready), 64'd1);
        idle_cycles(2);
        chk_stats("stats_after_kills");

        // Reset asserted while in RESOLVE
        issue(2'b00, 4'h0, 64'h7000, 64'd1, 64'd0, 1'b0, 1'b0, 64'd0);
        reset = 1'b0;
        #1;
        chk("reset_resolve_no_pulse", 64'(resolve_valid), 64'd0);
        exp_res = 0; exp_tak = 0;
        idle_cycles(2);
        chk("reset_taken_cleared", 64'(resolve_taken), 64'd0);
        chk("reset_target_cleared", resolve_target, 64'd0);
        chk_stats("stats_after_reset");
        reset = 1'b1;
        idle_cycles(1);
        chk("ready_after_reset", 64'(br_ready), 64'd1);

        // Sweep every condition against every NZCV; odd codes use the forwarded write path
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                bn = f[3]; bz = f[2]; bc = f[1]; bv = f[0];
                if (c[0]) begin
                    flag_wr_en = 1'b1;
                    flag_pending = bv;
                    {flag_n_in, flag_z_in, flag_c_in, flag_v_in} = {bn, bz, bc, bv};
                    {flag_n, flag_z, flag_c, flag_v} = ~{bn, bz, bc, bv};
                end else begin
                    flag_wr_en = 1'b0;
                    flag_pending = 1'b0;
                    {flag_n, flag_z, flag_c, flag_v} = {bn, bz, bc, bv};
                    {flag_n_in, flag_z_in, flag_c_in, flag_v_in} = ~{bn, bz, bc, bv};
                end
                exp_t_bit = cond_model(4'(c), bn, bz, bc, bv);
                pc  = 64'h1_0000 + 64'(c * 256 + f * 16);
                off = 64'(f) - 64'd8;
                issue(2'b11, 4'(c), pc, off, 64'd0, 1'b1, exp_t_bit, pc + (off << 2));
            end
        end
        flag_wr_en = 1'b0; flag_pending = 1'b0;

        drain = 0;
        while (sb.size() != 0 && drain < 20) begin
            @(posedge clk); #1;
            drain++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        chk_stats("stats_saturated");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
